// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and field-width constants for the direct-mapped
//                write-through data cache.
//                  - state_e    : controller FSM states (IDLE, FILL, WRITE)
//                  - fld_w()    : width of an address field indexing 'count'
//                  - c_DEF_*    : default geometry and derived field widths
//  Revision    : 1.0  initial release
// ============================================================================
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2
    } state_e;

    // Byte-within-word bits of every address; always ignored by the cache.
    localparam int c_BYTE_W = 2;

    // Width of an address field that selects one of 'count' items.
    function automatic int fld_w(input int count);
        return $clog2(count);
    endfunction

    localparam int c_DEF_N     = 32;
    localparam int c_DEF_LINES = 8;
    localparam int c_DEF_WORDS = 4;
    localparam int c_DEF_OFF_W = fld_w(c_DEF_WORDS);
    localparam int c_DEF_IDX_W = fld_w(c_DEF_LINES);
    localparam int c_DEF_TAG_W = c_DEF_N - c_DEF_IDX_W - c_DEF_OFF_W - c_BYTE_W;

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_array
//  Description : Valid/tag/data storage for the direct-mapped cache.
//                One synchronous write port, one combinational read port.
//  Ports       : clk, reset (async, active low; clears valid bits only)
//                rd_idx/rd_off   -> rd_valid, rd_tag, rd_word
//                wr_en, wr_idx, wr_off, wr_word : word write
//                wr_fill_done, wr_tag           : with wr_en, mark line valid
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_array
    import dcache_pkg::*;
#(
    parameter int n     = c_DEF_N,
    parameter int LINES = c_DEF_LINES,
    parameter int WORDS = c_DEF_WORDS
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [fld_w(LINES)-1:0]                     rd_idx,
    input  logic [fld_w(WORDS)-1:0]                     rd_off,
    output logic                                        rd_valid,
    output logic [n-fld_w(LINES)-fld_w(WORDS)-c_BYTE_W-1:0] rd_tag,
    output logic [n-1:0]                                rd_word,
    input  logic                                        wr_en,
    input  logic [fld_w(LINES)-1:0]                     wr_idx,
    input  logic [fld_w(WORDS)-1:0]                     wr_off,
    input  logic [n-1:0]                                wr_word,
    input  logic                                        wr_fill_done,
    input  logic [n-fld_w(LINES)-fld_w(WORDS)-c_BYTE_W-1:0] wr_tag
);

    localparam int c_IDX_W = fld_w(LINES);
    localparam int c_OFF_W = fld_w(WORDS);
    localparam int c_TAG_W = n - c_IDX_W - c_OFF_W - c_BYTE_W;

    logic [LINES-1:0]   r_valid;
    logic [c_TAG_W-1:0] r_tag  [LINES];
    logic [n-1:0]       r_data [LINES*WORDS];

    // Only the valid bits need reset; stale tags/data are masked by valid=0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (wr_en && wr_fill_done) begin
            r_valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_data[{wr_idx, wr_off}] <= wr_word;
        end
        if (wr_en && wr_fill_done) begin
            r_tag[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = r_valid[rd_idx];
    assign rd_tag   = r_tag[rd_idx];
    assign rd_word  = r_data[{rd_idx, rd_off}];

endmodule : dcache_array
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Direct-mapped, write-through, no-write-allocate,
//                read-allocate data cache controller.
//  Ports       : clk, reset (async, active low)
//                cpu_re, cpu_we, cpu_addr, cpu_wdata -> cpu_rdata, stall
//                mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ready
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int n     = c_DEF_N,
    parameter int LINES = c_DEF_LINES,
    parameter int WORDS = c_DEF_WORDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_re,
    input  logic         cpu_we,
    input  logic [n-1:0] cpu_addr,
    input  logic [n-1:0] cpu_wdata,
    output logic [n-1:0] cpu_rdata,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic [n-1:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int c_IDX_W = fld_w(LINES);
    localparam int c_OFF_W = fld_w(WORDS);
    localparam int c_TAG_W = n - c_IDX_W - c_OFF_W - c_BYTE_W;
    localparam logic [c_OFF_W-1:0] c_LAST_BEAT = c_OFF_W'(WORDS - 1);

    state_e             r_state;
    logic [c_OFF_W-1:0] r_beat;

    logic [c_OFF_W-1:0] w_off;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_rd_valid;
    logic [c_TAG_W-1:0] w_rd_tag;
    logic [n-1:0]       w_rd_word;
    logic               w_hit;
    logic               w_last_beat;

    logic               w_wr_en;
    logic [c_OFF_W-1:0] w_wr_off;
    logic [n-1:0]       w_wr_word;
    logic               w_fill_done;

    // Byte-lane bits never matter to a word-granular cache.
    logic w_unused;
    assign w_unused = &{1'b0, cpu_addr[c_BYTE_W-1:0]};

    assign w_off       = cpu_addr[c_BYTE_W +: c_OFF_W];
    assign w_idx       = cpu_addr[c_BYTE_W + c_OFF_W +: c_IDX_W];
    assign w_tag       = cpu_addr[n-1 -: c_TAG_W];
    assign w_hit       = w_rd_valid && (w_rd_tag == w_tag);
    assign w_last_beat = (r_beat == c_LAST_BEAT);

    dcache_array #(
        .n     (n),
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_array (
        .clk          (clk),
        .reset        (reset),
        .rd_idx       (w_idx),
        .rd_off       (w_off),
        .rd_valid     (w_rd_valid),
        .rd_tag       (w_rd_tag),
        .rd_word      (w_rd_word),
        .wr_en        (w_wr_en),
        .wr_idx       (w_idx),
        .wr_off       (w_wr_off),
        .wr_word      (w_wr_word),
        .wr_fill_done (w_fill_done),
        .wr_tag       (w_tag)
    );

    // Outputs are decoded from the current state so that a hit answers in
    // the same cycle and a miss stalls the datapath immediately.
    always_comb begin
        cpu_rdata   = '0;
        stall       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        w_wr_en     = 1'b0;
        w_wr_off    = w_off;
        w_wr_word   = cpu_wdata;
        w_fill_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_we) begin
                    stall = 1'b1;
                end else if (cpu_re) begin
                    if (w_hit) begin
                        cpu_rdata = w_rd_word;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            S_FILL: begin
                stall       = 1'b1;
                mem_req     = 1'b1;
                mem_addr    = {w_tag, w_idx, r_beat, {c_BYTE_W{1'b0}}};
                w_wr_en     = mem_ready;
                w_wr_off    = r_beat;
                w_wr_word   = mem_rdata;
                w_fill_done = w_last_beat;
            end
            S_WRITE: begin
                stall     = !mem_ready;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {cpu_addr[n-1:c_BYTE_W], {c_BYTE_W{1'b0}}};
                mem_wdata = cpu_wdata;
                // No-write-allocate: only a resident line is updated.
                w_wr_en   = mem_ready && w_hit;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu_we) begin
                        r_state <= S_WRITE;
                    end else if (cpu_re && !w_hit) begin
                        r_state <= S_FILL;
                        r_beat  <= '0;
                    end
                end
                S_FILL: begin
                    if (mem_ready) begin
                        if (w_last_beat) begin
                            r_beat  <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : dcache_ctrl
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_ctrl
//  Description : Directed self-checking bench for dcache_ctrl with a simple
//                main-memory model (programmable ready latency).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_ctrl;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        cpu_re    = 1'b0;
    logic        cpu_we    = 1'b0;
    logic [31:0] cpu_addr  = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    int total = 0;
    int bad   = 0;
    int lat   = 0;
    int cnt   = 0;

    logic [31:0] mem [4096];
    logic [31:0] log_addr [$];
    logic        log_we [$];
    logic [31:0] log_wdata [$];

    dcache_ctrl #(
        .n     (32),
        .LINES (8),
        .WORDS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    // Memory responder: ready after 'lat' waiting cycles of a request; every
    // completed beat is logged and writes update the memory image.
    always @(negedge clk) begin
        if (!mem_req || !reset) begin
            cnt       = 0;
            mem_ready = 1'b0;
            mem_rdata = '0;
        end else if (cnt == lat) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr[13:2]];
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            log_wdata.push_back(mem_wdata);
            if (mem_we) mem[mem_addr[13:2]] = mem_wdata;
            cnt = 0;
        end else begin
            mem_ready = 1'b0;
            cnt++;
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_we.delete();
        log_wdata.delete();
    endtask

    task automatic run_load(input logic [31:0] a, output int stalls,
                            output logic [31:0] data, output logic mreq);
        @(posedge clk); #1;
        cpu_re = 1'b1; cpu_addr = a;
        stalls = 0; data = '0; mreq = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (!stall) begin
                data = cpu_rdata;
                mreq = mem_req;
                break;
            end
            stalls++;
        end
        @(posedge clk); #1;
        cpu_re = 1'b0;
    endtask

    task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                             output int stalls);
        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (!stall) break;
            stalls++;
        end
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
        total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", cpu_rdata); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_fill();
        int s; logic [31:0] d; logic mr;
        logic [31:0] want [4];
        want = '{32'h40, 32'h44, 32'h48, 32'h4C};
        lat = 0; clear_log();
        run_load(32'h40, s, d, mr);
        total++; if (s != 5) begin bad++; $display("FAIL fill_stalls got=%0d want=5", s); end
        total++; if (d !== 32'hC0DE0010) begin bad++; $display("FAIL fill_data got=%h want=c0de0010", d); end
        total++; if (log_addr.size() != 4) begin bad++; $display("FAIL fill_beats got=%0d want=4", log_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < log_addr.size()) begin
                total++;
                if (log_addr[i] !== want[i] || log_we[i] !== 1'b0) begin
                    bad++; $display("FAIL fill_beat%0d got=%h we=%b want=%h we=0", i, log_addr[i], log_we[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_hit();
        int s; logic [31:0] d; logic mr;
        clear_log();
        run_load(32'h4C, s, d, mr);
        total++; if (s != 0) begin bad++; $display("FAIL hit_stalls got=%0d want=0", s); end
        total++; if (mr !== 1'b0) begin bad++; $display("FAIL hit_mem_req got=%b want=0", mr); end
        total++; if (d !== 32'hC0DE0013) begin bad++; $display("FAIL hit_data got=%h want=c0de0013", d); end
        total++; if (log_addr.size() != 0) begin bad++; $display("FAIL hit_beats got=%0d want=0", log_addr.size()); end
    endtask

    task automatic test_store_hit();
        int s; logic [31:0] d; logic mr;
        lat = 2; clear_log();
        run_store(32'h48, 32'hDEADBEEF, s);
        total++; if (s != 3) begin bad++; $display("FAIL st_stalls got=%0d want=3", s); end
        total++; if (log_addr.size() != 1) begin bad++; $display("FAIL st_beats got=%0d want=1", log_addr.size()); end
        if (log_addr.size() >= 1) begin
            total++;
            if (log_addr[0] !== 32'h48 || log_we[0] !== 1'b1 || log_wdata[0] !== 32'hDEADBEEF) begin
                bad++; $display("FAIL st_beat got=%h we=%b d=%h want=48 we=1 d=deadbeef", log_addr[0], log_we[0], log_wdata[0]);
            end
        end
        lat = 0; clear_log();
        run_load(32'h48, s, d, mr);
        total++; if (s != 0) begin bad++; $display("FAIL st_reload_stalls got=%0d want=0", s); end
        total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL st_reload_data got=%h want=deadbeef", d); end
    endtask

    task automatic test_store_miss();
        int s; logic [31:0] d; logic mr;
        lat = 0; clear_log();
        run_store(32'h1000, 32'h12345678, s);
        total++; if (s != 1) begin bad++; $display("FAIL sm_stalls got=%0d want=1", s); end
        clear_log();
        run_load(32'h1000, s, d, mr);
        total++; if (s != 5) begin bad++; $display("FAIL sm_load_stalls got=%0d want=5", s); end
        total++; if (d !== 32'h12345678) begin bad++; $display("FAIL sm_load_data got=%h want=12345678", d); end
        total++;
        if (log_addr.size() != 4 || log_addr[0] !== 32'h1000 || log_addr[3] !== 32'h100C) begin
            bad++; $display("FAIL sm_beats n=%0d want 4 beats 1000..100c", log_addr.size());
        end
    endtask

    task automatic test_conflict();
        int s; logic [31:0] d; logic mr;
        clear_log();
        run_load(32'h240, s, d, mr);
        total++; if (s != 5) begin bad++; $display("FAIL cf_stalls got=%0d want=5", s); end
        total++; if (d !== 32'hC0DE0090) begin bad++; $display("FAIL cf_data got=%h want=c0de0090", d); end
        total++; if (log_addr.size() < 1 || log_addr[0] !== 32'h240) begin bad++; $display("FAIL cf_first_beat n=%0d want 240", log_addr.size()); end
        run_load(32'h40, s, d, mr);
        total++; if (s != 5) begin bad++; $display("FAIL cf_back_stalls got=%0d want=5", s); end
        total++; if (d !== 32'hC0DE0010) begin bad++; $display("FAIL cf_back_data got=%h want=c0de0010", d); end
        run_load(32'h48, s, d, mr);
        total++; if (s != 0) begin bad++; $display("FAIL cf_hit_stalls got=%0d want=0", s); end
        total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL cf_hit_data got=%h want=deadbeef", d); end
    endtask

    task automatic test_reset_abort();
        int s; logic [31:0] d; logic mr;
        lat = 0;
        @(posedge clk); #1;
        cpu_re = 1'b1; cpu_addr = 32'h240;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h248) begin bad++; $display("FAIL ab_beat2 req=%b addr=%h want req=1 addr=248", mem_req, mem_addr); end
        reset = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL ab_req_drop req=%b we=%b want 0 0", mem_req, mem_we); end
        cpu_re = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL ab_stall got=%b want=0", stall); end
        @(posedge clk); #1;
        reset = 1'b1;
        clear_log();
        run_load(32'h40, s, d, mr);
        total++; if (s != 5) begin bad++; $display("FAIL ab_refill_stalls got=%0d want=5", s); end
        total++; if (d !== 32'hC0DE0010) begin bad++; $display("FAIL ab_refill_data got=%h want=c0de0010", d); end
        total++; if (log_addr.size() != 4 || log_addr[0] !== 32'h40) begin bad++; $display("FAIL ab_refill_beats n=%0d want 4 from 40", log_addr.size()); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = {16'hC0DE, 2'b00, i[13:0]};
        test_reset();
        test_fill();
        test_hit();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dcache_ctrl
`default_nettype wire

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have parameter n, default 32: data/address width.
REQ-002 The block SHALL have parameter LINES, default 8: number of direct-mapped lines (power of two).
REQ-003 The block SHALL have parameter WORDS, default 4: 32-bit words per line (power of two).
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port cpu_re  input  1  load request from datapath (memread).
REQ-007 The block SHALL have port cpu_we  input  1  store request from datapath (memwrite).
REQ-008 The block SHALL have port cpu_addr  input  n  byte address (datapath aluout).
REQ-009 The block SHALL have port cpu_wdata  input  n  store data (datapath writedata).
REQ-010 The block SHALL have port cpu_rdata  output  n  load data (datapath readdata).
REQ-011 The block SHALL have port stall  output  1  high = datapath must hold PC and register writes.
REQ-012 The block SHALL have port mem_req  output  1  main-memory request valid.
REQ-013 The block SHALL have port mem_we  output  1  main-memory request is a write.
REQ-014 The block SHALL have port mem_addr  output  n  word-aligned main-memory address.
REQ-015 The block SHALL have port mem_wdata  output  n  main-memory write data.
REQ-016 The block SHALL have port mem_rdata  input  n  main-memory read data, valid with mem_ready.
REQ-017 The block SHALL have port mem_ready  input  1  one-cycle completion of the current beat.

Function
REQ-018 Address split SHALL be: [1:0] ignored, [log2(WORDS)+1:2] word offset, next log2(LINES) bits index, remainder tag (defaults: [3:2], [6:4], [31:7]).
REQ-019 Policy SHALL be write-through, no-write-allocate, read-allocate.
REQ-020 FSM states SHALL be IDLE, FILL, WRITE.
REQ-021 IDLE, cpu_re, hit (valid and tag match): cpu_rdata = cached word combinationally, stall=0, no memory request.
REQ-022 IDLE, cpu_re, miss: stall=1 that cycle; next state FILL; beat counter cleared to 0.
REQ-023 FILL: mem_req=1, mem_we=0, mem_addr={tag,index,beat,2'b00}; stall=1; each mem_ready cycle writes mem_rdata into word[beat] and increments beat.
REQ-024 FILL: on mem_ready with beat=WORDS-1, line valid and tag are set, beat wraps to 0, next state IDLE; the retried load then hits one cycle later.
REQ-025 IDLE, cpu_we: stall=1; next state WRITE; takes precedence if cpu_re and cpu_we are both high.
REQ-026 WRITE: mem_req=1, mem_we=1, mem_addr={cpu_addr[n-1:2],2'b00}, mem_wdata=cpu_wdata; stall=!mem_ready.
REQ-027 WRITE, mem_ready: on hit, cached word updated with cpu_wdata; on miss, cache unchanged; next state IDLE.
REQ-028 mem_req, mem_we SHALL be 0 in IDLE; mem_addr/mem_wdata are don't-care when mem_req=0.
REQ-029 No cpu_re/cpu_we in IDLE: stall=0, cpu_rdata=0, state holds.
REQ-030 cpu_addr/cpu_wdata SHALL be held stable by the stalled datapath; the block does not latch them.

Reset
REQ-031 reset low SHALL asynchronously force state=IDLE, beat=0, all valid bits=0; outputs mem_req=0, mem_we=0, stall=0 while reset low and cpu inactive.
REQ-032 Reset mid-FILL or mid-WRITE SHALL abort the transaction; partially filled line stays invalid; tag/data arrays need no reset.

Structure
REQ-033 Package dcache_pkg SHALL hold the state enum and field-width constants derived from LINES/WORDS.
REQ-034 Tag/valid/data storage SHALL be one sub-module, dcache_array (one write port, one combinational read port).

Verification
REQ-035 Reset, load 0x00000040 -> stall=1, four read beats at 0x40,0x44,0x48,0x4C (mem_ready each cycle), then one cycle later stall=0, cpu_rdata=mem[0x40].
REQ-036 Following load 0x0000004C -> hit: stall=0, mem_req=0, cpu_rdata=mem[0x4C].
REQ-037 Store 0x48 data 0xDEADBEEF, mem_ready after 3 cycles -> mem_we=1 at 0x48, stall high 3 cycles then low; load 0x48 hits returning 0xDEADBEEF.
REQ-038 Store 0x00001000 (miss) then load 0x00001000 -> store leaves cache unchanged; load misses and fills 0x1000-0x100C.
REQ-039 Load 0x240 after line 0x40 valid -> conflict miss, refill replaces tag; load 0x40 misses again.
REQ-040 reset low during beat 2 of a fill -> mem_req drops immediately; after release, load 0x40 misses and refetches from beat 0.
